// File: rtl/shift_pkg.sv
// Shared types and helpers for the multi-cycle shift sequencer.
package shift_pkg;

    localparam int DEFAULT_N    = 8;
    localparam int DEFAULT_STEP = 3;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } shift_state_t;

    typedef enum logic {
        SHIFT_LEFT  = 1'b0,
        SHIFT_RIGHT = 1'b1
    } shift_dir_t;

    function automatic int min_amt(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/shift_step_unit.sv
// Combinational bounded shifter: moves data by s (0..STEP) bits, vacated bits take fill.
module shift_step_unit
    import shift_pkg::*;
#(
    parameter int N    = DEFAULT_N,
    parameter int STEP = DEFAULT_STEP
) (
    input  logic [N-1:0]                 data,
    input  logic [$clog2(STEP+1)-1:0]    s,
    input  shift_dir_t                   dir,
    input  logic                         fill,
    output logic [N-1:0]                 result
);

    logic [N+STEP-1:0] left_ext;
    logic [N+STEP-1:0] right_ext;

    // Pre-padded operands let every step distance be a plain window select.
    assign left_ext  = {data, {STEP{fill}}};
    assign right_ext = {{STEP{fill}}, data};

    always_comb begin
        result = data;
        for (int k = 0; k <= STEP; k++) begin
            if (int'(s) == k) begin
                if (dir == SHIFT_RIGHT) begin
                    result = right_ext[k +: N];
                end else begin
                    result = left_ext[STEP-k +: N];
                end
            end
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: sequences a small shift_step_unit until the
// requested amount is consumed, with valid/ready on both sides.
module shift_sequencer
    import shift_pkg::*;
#(
    parameter int N    = DEFAULT_N,
    parameter int STEP = DEFAULT_STEP,
    parameter int AW   = $clog2(N) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic [AW-1:0] in_amt,
    input  logic          in_dir,
    input  logic          in_arith,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data
);

    localparam int RW = $clog2(N + 1);
    localparam int SW = $clog2(STEP + 1);

    shift_state_t  state_reg;
    logic [N-1:0]  data_reg;
    logic [RW-1:0] rem_reg;
    shift_dir_t    dir_reg;
    logic          fill_reg;
    logic          in_ready_reg;
    logic          out_valid_reg;
    logic [N-1:0]  out_data_reg;

    logic [RW-1:0] amt_sat;
    logic [SW-1:0] step_amt;
    logic [N-1:0]  step_data;

    always_comb begin
        amt_sat  = RW'(min_amt(int'(in_amt), N));
        step_amt = SW'(min_amt(int'(rem_reg), STEP));
    end

    shift_step_unit #(
        .N    (N),
        .STEP (STEP)
    ) u_step (
        .data   (data_reg),
        .s      (step_amt),
        .dir    (dir_reg),
        .fill   (fill_reg),
        .result (step_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            data_reg      <= '0;
            rem_reg       <= '0;
            dir_reg       <= SHIFT_LEFT;
            fill_reg      <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        data_reg     <= in_data;
                        dir_reg      <= shift_dir_t'(in_dir);
                        fill_reg     <= in_dir & in_arith & in_data[N-1];
                        rem_reg      <= amt_sat;
                        in_ready_reg <= 1'b0;
                        state_reg    <= (amt_sat != '0) ? SHIFT : DONE;
                    end
                end
                SHIFT: begin
                    data_reg <= step_data;
                    rem_reg  <= rem_reg - RW'(step_amt);
                    if (rem_reg == RW'(step_amt)) begin
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    // First DONE cycle publishes the result; later cycles wait for the consumer.
                    if (!out_valid_reg) begin
                        out_valid_reg <= 1'b1;
                        out_data_reg  <= data_reg;
                    end else if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg    <= IDLE;
                    in_ready_reg <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;

endmodule
